// File: rtl/branch_cond_pkg.sv
// Pu_types: shared types and constants for the branch-condition unit.
//   Branch_bo          - 5-bit PowerPC BO field, bo[4]=BO_0 ... bo[0]=BO_4
//   Condition_register - 32-bit CR viewed as 8 fields of 4 bits (cr[field][bit])
//   BO_* constants     - bit positions inside Branch_bo
//   cr_bit_index()     - flat CR bit position selected by a BI field
package Pu_types;

  typedef logic [4:0]      Branch_bo;
  typedef logic [7:0][3:0] Condition_register;

  localparam int unsigned BO_IGNORE_COND = 32'd4;  // 1: ignore the CR bit
  localparam int unsigned BO_COND_VAL    = 32'd3;  // required CR bit value
  localparam int unsigned BO_NO_DEC      = 32'd2;  // 1: do not touch CTR
  localparam int unsigned BO_CTR_ZERO    = 32'd1;  // 1: branch when CTR==0
  localparam int unsigned BO_HINT        = 32'd0;  // prediction hint only

  // bi[1:0]=00 addresses field bit 3 (LT), 11 addresses field bit 0 (SO).
  function automatic logic [4:0] cr_bit_index(input logic [4:0] bi);
    logic [1:0] bit_in_field;
    bit_in_field = 2'd3 - bi[1:0];
    return {bi[4:2], bit_in_field};
  endfunction

endpackage

// File: rtl/branch_cond_eval.sv
// Branch_eval: purely combinational BO/BI evaluation.
//   bo_i, bi_i, cr_i  - branch fields and current condition register
//   ctr_src_i         - CTR value the decrement starts from
//   ctr_next_o        - CTR after the optional decrement
//   taken_o           - branch resolves taken; bo[0] never affects it
//   ctr_zero_o        - a decrement happened and produced 0
module Branch_eval
  import Pu_types::*;
(
  input  Branch_bo          bo_i,
  input  logic [4:0]        bi_i,
  input  Condition_register cr_i,
  input  logic [31:0]       ctr_src_i,
  output logic [31:0]       ctr_next_o,
  output logic              taken_o,
  output logic              ctr_zero_o
);

  logic [31:0] cr_flat_s;
  logic        crbit_s;
  logic        cond_ok_s;
  logic        ctr_ok_s;
  logic        ctr_nz_s;

  // Condition test, CTR decrement and final taken decision.
  always_comb begin
    cr_flat_s  = cr_i;
    crbit_s    = cr_flat_s[cr_bit_index(bi_i)];
    cond_ok_s  = bo_i[BO_IGNORE_COND] | (crbit_s == bo_i[BO_COND_VAL]);
    if (bo_i[BO_NO_DEC]) begin
      ctr_next_o = ctr_src_i;
    end else begin
      ctr_next_o = ctr_src_i - 32'd1;  // wraps 0 -> 0xFFFF_FFFF
    end
    ctr_nz_s   = (ctr_next_o != 32'd0);
    ctr_ok_s   = bo_i[BO_NO_DEC] | (ctr_nz_s ^ bo_i[BO_CTR_ZERO]);
    taken_o    = cond_ok_s & ctr_ok_s;
    ctr_zero_o = ~bo_i[BO_NO_DEC] & ~ctr_nz_s;
  end

endmodule

// File: rtl/branch_cond.sv
// branch_cond: one-stage pipelined branch-condition unit owning the CTR.
//   clk, reset (async, active low)
//   in_valid/in_ready  - request handshake; bo, bi, cr carry the request
//   ctr_we/ctr_wdata   - mtctr write port
//   ctr                - registered architectural CTR
//   out_valid/out_ready, taken, ctr_zero - registered result handshake
// Option macro BRANCH_COND_CTR_FWD_EN: forward ctr_wdata into a same-cycle
// request instead of stalling it for one cycle.
module branch_cond
  import Pu_types::*;
(
  input  logic              clk,
  input  logic              reset,
  input  logic              in_valid,
  output logic              in_ready,
  input  Branch_bo          bo,
  input  logic [4:0]        bi,
  input  Condition_register cr,
  input  logic              ctr_we,
  input  logic [31:0]       ctr_wdata,
  output logic [31:0]       ctr,
  output logic              out_valid,
  input  logic              out_ready,
  output logic              taken,
  output logic              ctr_zero
);

  logic [31:0] ctr_q, ctr_d;
  logic        out_valid_q, out_valid_d;
  logic        taken_q, taken_d;
  logic        ctr_zero_q, ctr_zero_d;

  logic [31:0] ctr_src_s;
  logic [31:0] ctr_next_s;
  logic        eval_taken_s;
  logic        eval_zero_s;
  logic        accept_s;
  logic        dec_accept_s;

  Branch_eval u_eval (
    .bo_i       (bo),
    .bi_i       (bi),
    .cr_i       (cr),
    .ctr_src_i  (ctr_src_s),
    .ctr_next_o (ctr_next_s),
    .taken_o    (eval_taken_s),
    .ctr_zero_o (eval_zero_s)
  );

  // CTR source selection and the input-side handshake.
  always_comb begin
`ifdef BRANCH_COND_CTR_FWD_EN
    if (ctr_we) begin
      ctr_src_s = ctr_wdata;
    end else begin
      ctr_src_s = ctr_q;
    end
    in_ready = ~out_valid_q | out_ready;
`else
    // A pending mtctr holds the request off so it sees the new CTR.
    ctr_src_s = ctr_q;
    in_ready  = (~out_valid_q | out_ready) & ~ctr_we;
`endif
    accept_s     = in_valid & in_ready;
    dec_accept_s = accept_s & ~bo[BO_NO_DEC];
  end

  // Next-state for CTR and the result register.
  always_comb begin
    // A decrementing accept wins over a plain CTR write; with forwarding
    // its ctr_next already starts from ctr_wdata.
    if (dec_accept_s) begin
      ctr_d = ctr_next_s;
    end else if (ctr_we) begin
      ctr_d = ctr_wdata;
    end else begin
      ctr_d = ctr_q;
    end

    if (accept_s) begin
      out_valid_d = 1'b1;
      taken_d     = eval_taken_s;
      ctr_zero_d  = eval_zero_s;
    end else if (out_ready) begin
      out_valid_d = 1'b0;
      taken_d     = taken_q;
      ctr_zero_d  = ctr_zero_q;
    end else begin
      out_valid_d = out_valid_q;
      taken_d     = taken_q;
      ctr_zero_d  = ctr_zero_q;
    end
  end

  // State registers; reset clears everything and drops any held result.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      ctr_q       <= 32'd0;
      out_valid_q <= 1'b0;
      taken_q     <= 1'b0;
      ctr_zero_q  <= 1'b0;
    end else begin
      ctr_q       <= ctr_d;
      out_valid_q <= out_valid_d;
      taken_q     <= taken_d;
      ctr_zero_q  <= ctr_zero_d;
    end
  end

  assign ctr       = ctr_q;
  assign out_valid = out_valid_q;
  assign taken     = taken_q;
  assign ctr_zero  = ctr_zero_q;

endmodule

// File: tb/tb_branch_cond.sv
// Directed self-checking bench for branch_cond. Expected values are
// hand-computed constants; BRANCH_COND_CTR_FWD_EN selects the matching
// expectations for the CTR write collision case.
module tb_branch_cond;

  logic        clk;
  logic        reset;
  logic        in_valid;
  logic        in_ready;
  logic [4:0]  bo;
  logic [4:0]  bi;
  logic [31:0] cr;
  logic        ctr_we;
  logic [31:0] ctr_wdata;
  logic [31:0] ctr;
  logic        out_valid;
  logic        out_ready;
  logic        taken;
  logic        ctr_zero;

  int checks_cnt;
  int fail_cnt;

  branch_cond dut (
    .clk       (clk),
    .reset     (reset),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .bo        (bo),
    .bi        (bi),
    .cr        (cr),
    .ctr_we    (ctr_we),
    .ctr_wdata (ctr_wdata),
    .ctr       (ctr),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .taken     (taken),
    .ctr_zero  (ctr_zero)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
    checks_cnt++;
    if (act !== exp) begin
      fail_cnt++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, act, exp);
    end
  endtask

  // Advance to just after the next rising edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic load_ctr(input logic [31:0] v);
    in_valid  = 1'b0;
    ctr_we    = 1'b1;
    ctr_wdata = v;
    tick();
    ctr_we    = 1'b0;
  endtask

  // Present one request for one accepting cycle, then drop in_valid.
  task automatic issue(input logic [4:0] b, input logic [4:0] s, input logic [31:0] c);
    bo       = b;
    bi       = s;
    cr       = c;
    in_valid = 1'b1;
    #1;
    check_eq("in_ready_issue", {31'd0, in_ready}, 32'd1);
    tick();
    in_valid = 1'b0;
  endtask

  initial begin
    checks_cnt = 0;
    fail_cnt   = 0;
    reset      = 1'b0;
    in_valid   = 1'b0;
    bo         = 5'd0;
    bi         = 5'd0;
    cr         = 32'd0;
    ctr_we     = 1'b0;
    ctr_wdata  = 32'd0;
    out_ready  = 1'b1;

    #12;
    check_eq("rst_ctr",       ctr,                   32'd0);
    check_eq("rst_out_valid", {31'd0, out_valid},    32'd0);
    check_eq("rst_taken",     {31'd0, taken},        32'd0);
    check_eq("rst_ctr_zero",  {31'd0, ctr_zero},     32'd0);
    @(negedge clk);
    reset = 1'b1;
    tick();

    // Scenario 1: no decrement, condition ignored.
    load_ctr(32'd5);
    check_eq("s1_ctr_load", ctr, 32'd5);
    issue(5'b10100, 5'b00000, 32'h0000_0000);
    check_eq("s1_valid", {31'd0, out_valid}, 32'd1);
    check_eq("s1_taken", {31'd0, taken},     32'd1);
    check_eq("s1_zero",  {31'd0, ctr_zero},  32'd0);
    check_eq("s1_ctr",   ctr,                32'd5);
    tick();
    check_eq("s1_drain", {31'd0, out_valid}, 32'd0);

    // Scenario 2: decrement to zero, branch if zero, CR bit must be 0.
    load_ctr(32'd1);
    issue(5'b00010, 5'b00000, 32'h0000_0000);
    check_eq("s2_ctr",   ctr,               32'd0);
    check_eq("s2_zero",  {31'd0, ctr_zero}, 32'd1);
    check_eq("s2_taken", {31'd0, taken},    32'd1);

    // Scenario 3: decrement wraps, branch if nonzero.
    issue(5'b10000, 5'b00000, 32'h0000_0000);
    check_eq("s3_ctr",   ctr,               32'hFFFF_FFFF);
    check_eq("s3_taken", {31'd0, taken},    32'd1);
    check_eq("s3_zero",  {31'd0, ctr_zero}, 32'd0);

    // Branch-if-zero with a nonzero result is not taken.
    issue(5'b00010, 5'b00000, 32'h0000_0000);
    check_eq("bz_ctr",   ctr,            32'hFFFF_FFFE);
    check_eq("bz_taken", {31'd0, taken}, 32'd0);

    // CR bit select: field 2 bit 3 is flat bit 11, field 2 bit 0 is bit 8.
    issue(5'b01100, 5'b01000, 32'h0000_0800);
    check_eq("crsel_lt_taken", {31'd0, taken}, 32'd1);
    issue(5'b01100, 5'b01011, 32'h0000_0800);
    check_eq("crsel_so_taken", {31'd0, taken}, 32'd0);
    issue(5'b01101, 5'b01000, 32'h0000_0800);
    check_eq("hint_taken",     {31'd0, taken}, 32'd1);
    issue(5'b00100, 5'b01000, 32'h0000_0800);
    check_eq("cond0_taken",    {31'd0, taken}, 32'd0);
    check_eq("nodec_ctr",      ctr,            32'hFFFF_FFFE);
    tick();

    // Scenario 4: consumer stalls three cycles with a request pending.
    load_ctr(32'd10);
    out_ready = 1'b0;
    issue(5'b10000, 5'b00000, 32'h0000_0000);
    check_eq("s4_ctr_first", ctr, 32'd9);
    in_valid = 1'b1;
    for (int i = 0; i < 3; i++) begin
      check_eq("s4_in_ready", {31'd0, in_ready},  32'd0);
      check_eq("s4_valid",    {31'd0, out_valid}, 32'd1);
      check_eq("s4_taken",    {31'd0, taken},     32'd1);
      check_eq("s4_zero",     {31'd0, ctr_zero},  32'd0);
      check_eq("s4_ctr_hold", ctr,                32'd9);
      tick();
    end
    out_ready = 1'b1;
    #1;
    check_eq("s4_ready_rel", {31'd0, in_ready}, 32'd1);
    tick();
    in_valid = 1'b0;
    check_eq("s4_b2b_valid", {31'd0, out_valid}, 32'd1);
    check_eq("s4_b2b_ctr",   ctr,                32'd8);
    tick();
    check_eq("s4_drain", {31'd0, out_valid}, 32'd0);

    // Scenario 5: CTR write collides with a decrementing request.
    ctr_we    = 1'b1;
    ctr_wdata = 32'd3;
    bo        = 5'b10000;
    bi        = 5'b00000;
    cr        = 32'h0000_0000;
    in_valid  = 1'b1;
    #1;
`ifdef BRANCH_COND_CTR_FWD_EN
    check_eq("s5_in_ready", {31'd0, in_ready}, 32'd1);
    tick();
    ctr_we   = 1'b0;
    in_valid = 1'b0;
`else
    check_eq("s5_in_ready", {31'd0, in_ready}, 32'd0);
    tick();
    ctr_we = 1'b0;
    check_eq("s5_ctr_wr",    ctr,                32'd3);
    check_eq("s5_not_valid", {31'd0, out_valid}, 32'd0);
    #1;
    check_eq("s5_ready_nx", {31'd0, in_ready}, 32'd1);
    tick();
    in_valid = 1'b0;
`endif
    check_eq("s5_ctr",   ctr,                32'd2);
    check_eq("s5_valid", {31'd0, out_valid}, 32'd1);
    check_eq("s5_taken", {31'd0, taken},     32'd1);
    tick();

    // Scenario 6: asynchronous reset during a stall.
    load_ctr(32'd7);
    out_ready = 1'b0;
    issue(5'b10000, 5'b00000, 32'h0000_0000);
    check_eq("s6_pre_valid", {31'd0, out_valid}, 32'd1);
    check_eq("s6_pre_ctr",   ctr,                32'd6);
    #2;
    reset = 1'b0;
    #1;
    check_eq("s6_valid", {31'd0, out_valid}, 32'd0);
    check_eq("s6_ctr",   ctr,                32'd0);
    check_eq("s6_taken", {31'd0, taken},     32'd0);
    @(negedge clk);
    reset     = 1'b1;
    out_ready = 1'b1;
    tick();
    check_eq("s6_post_valid", {31'd0, out_valid}, 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks_cnt, fail_cnt);
    $finish;
  end

endmodule
